// File: rtl/cpu_trace_serializer_if.sv
// Record handshake between a CPU write-back producer and the trace serializer.
// valid/ready: a record transfers on a rising clk edge where in_valid && in_ready;
// the producer holds in_valid and all in_* fields stable until that edge.
`timescale 1ns/1ps
interface cpu_trace_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
    output in_ready
  );
endinterface

// File: rtl/cpu_trace_serializer.sv
// Serialises one write-back record into an ASCII trace line, one char per clock,
// after a 14-cycle double-dabble conversion of the time field.
`timescale 1ns/1ps
module cpu_trace_serializer #(
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu_trace_serializer_if.slave        rec,
  output logic [7:0]                   char,
  output logic                         frame_done,
  output logic [1:0]                   dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, EMIT = 2'd2} state_t;
  // slot = position in the longest possible line; slots absent from a frame are skipped
  localparam logic [5:0] SLOT_LAST = 6'd37;

  state_t      state, state_next;
  logic [5:0]  slot, slot_next;
  logic [3:0]  conv_cnt;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [11:0] bcd_adj;
  logic        kind;
  logic [31:0] pc, addr, data;
  logic [4:0]  grf;
  logic [3:0]  grf_tens, grf_ones;
  logic [7:0]  char_next;
  logic        frame_done_next, ready_next, in_ready_q, accept;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  assign accept       = rec.in_valid && in_ready_q;
  assign rec.in_ready = in_ready_q;
  assign dbg_state    = state;
  assign grf_tens     = 4'(grf / 5'd10);
  assign grf_ones     = 4'(grf % 5'd10);

  // Thousands digit never reaches 5 before the last shift (input saturates at 9999)
  always_comb begin
    for (int i = 0; i < 3; i++)
      bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      slot       <= 6'd0;
      char       <= IDLE_CHAR;
      frame_done <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      slot       <= slot_next;
      char       <= char_next;
      frame_done <= frame_done_next;
      in_ready_q <= ready_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      conv_cnt <= 4'd0;
      bin      <= 14'd0;
      bcd      <= 16'd0;
      kind     <= 1'b0;
      pc       <= 32'd0;
      grf      <= 5'd0;
      addr     <= 32'd0;
      data     <= 32'd0;
    end else if (state == IDLE && accept) begin
      conv_cnt <= 4'd0;
      bin      <= (rec.in_time > 14'd9999) ? 14'd9999 : rec.in_time;
      bcd      <= 16'd0;
      kind     <= rec.in_kind;
      pc       <= rec.in_pc;
      grf      <= rec.in_grf;
      addr     <= rec.in_addr;
      data     <= rec.in_data;
    end else if (state == CONV) begin
      conv_cnt <= conv_cnt + 4'd1;
      bcd      <= {bcd[14:12], bcd_adj, bin[13]};
      bin      <= {bin[12:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state;
    slot_next  = slot;
    unique case (state)
      IDLE: if (accept) state_next = CONV;
      CONV: if (conv_cnt == 4'd13) begin
        state_next = EMIT;
        slot_next  = 6'd0;
      end
      EMIT: begin
        if (slot == SLOT_LAST) begin
          state_next = IDLE;
          slot_next  = 6'd0;
        end else begin
          case (slot)
            6'd0: begin
              if (bcd[15:12] != 4'd0)     slot_next = 6'd1;
              else if (bcd[11:8] != 4'd0) slot_next = 6'd2;
              else if (bcd[7:4] != 4'd0)  slot_next = 6'd3;
              else                        slot_next = 6'd4;
            end
            6'd16:   slot_next = (kind || grf_tens != 4'd0) ? 6'd17 : 6'd18;
            6'd18:   slot_next = kind ? 6'd19 : 6'd25;
            default: slot_next = slot + 6'd1;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    char_next       = IDLE_CHAR;
    frame_done_next = 1'b0;
    ready_next      = (state_next == IDLE);
    if (state_next == EMIT) begin
      frame_done_next = (slot_next == SLOT_LAST);
      case (slot_next) inside
        6'd0:           char_next = 8'h5e;
        6'd1:           char_next = hex_char(bcd[15:12]);
        6'd2:           char_next = hex_char(bcd[11:8]);
        6'd3:           char_next = hex_char(bcd[7:4]);
        6'd4:           char_next = hex_char(bcd[3:0]);
        6'd5:           char_next = 8'h40;
        [6'd6:6'd13]:   char_next = hex_char(nib(pc, 3'(6'd13 - slot_next)));
        6'd14:          char_next = 8'h3a;
        6'd15:          char_next = 8'h20;
        6'd16:          char_next = kind ? 8'h2a : 8'h24;
        6'd17:          char_next = kind ? hex_char(nib(addr, 3'd7)) : hex_char(grf_tens);
        6'd18:          char_next = kind ? hex_char(nib(addr, 3'd6)) : hex_char(grf_ones);
        [6'd19:6'd24]:  char_next = hex_char(nib(addr, 3'(6'd24 - slot_next)));
        6'd25, 6'd28:   char_next = 8'h20;
        6'd26:          char_next = 8'h3c;
        6'd27:          char_next = 8'h3d;
        [6'd29:6'd36]:  char_next = hex_char(nib(data, 3'(6'd36 - slot_next)));
        6'd37:          char_next = 8'h23;
        default:        char_next = IDLE_CHAR;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Bench for cpu_trace_serializer: directed trace lines, handshake spacing, mid-frame
// reset and randomized records, all checked against a string-level line model.
`timescale 1ns/1ps
module tb_cpu_trace_serializer;
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char;
  logic       frame_done;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  cpu_trace_serializer_if bus();

  cpu_trace_serializer #(.IDLE_CHAR(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rec        (bus),
    .char       (char),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: the trace line as text
  task automatic build_frame(input logic k, input logic [13:0] t, input logic [31:0] p,
                             input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
    string s;
    int    ts;
    ts = (int'(t) > 9999) ? 9999 : int'(t);
    s = $sformatf("^%0d@%08h: ", ts, p);
    if (k) s = {s, $sformatf("*%08h", a)};
    else   s = {s, $sformatf("$%0d", g)};
    s = {s, $sformatf(" <= %08h#", d)};
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // driver + scoreboard for one record; called and returns at a falling edge
  task automatic run_frame(input logic k, input logic [13:0] t, input logic [31:0] p,
                           input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                           input bit drop_valid, input int abort_at, input string lit,
                           output int waits);
    string got;
    int    n;
    logic [7:0] e;
    build_frame(k, t, p, g, a, d);
    bus.in_kind = k; bus.in_time = t; bus.in_pc = p;
    bus.in_grf = g;  bus.in_addr = a; bus.in_data = d;
    bus.in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.in_ready && waits < 200);
    check("accept_ready", bus.in_ready, 1'b1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    check("pre_accept_char", char, IDLE);
    @(posedge clk);
    if (drop_valid) begin
      #1;
      bus.in_valid = 1'b0;
      bus.in_kind = 1'($urandom); bus.in_time = 14'($urandom); bus.in_pc = $urandom;
      bus.in_grf = 5'($urandom);  bus.in_addr = $urandom;      bus.in_data = $urandom;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check("conv_char", char, IDLE);
      check("conv_ready", bus.in_ready, 1'b0);
      check("conv_done", frame_done, 1'b0);
    end
    got = "";
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n++;
      @(negedge clk);
      check($sformatf("char[%0d]", n), char, e);
      check("frame_done", frame_done, exp_q.size() == 0);
      check("busy_ready", bus.in_ready, 1'b0);
      got = {got, $sformatf("%c", char)};
      if (n == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_char", char, IDLE);
        check("abort_ready", bus.in_ready, 1'b1);
        check("abort_done", frame_done, 1'b0);
        exp_q.delete();
        return;
      end
    end
    if (lit.len() > 0) check({"line ", lit}, got == lit, 1'b1);
  endtask

  task automatic idle_watch(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("idle_char", char, IDLE);
      check("idle_done", frame_done, 1'b0);
      check("idle_ready", bus.in_ready, 1'b1);
    end
  endtask

  initial begin
    int w;
    logic k;
    logic [13:0] t;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_kind = 1'b0; bus.in_time = '0;
    bus.in_pc = '0; bus.in_grf = '0; bus.in_addr = '0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    check("reset_char", char, IDLE);
    check("reset_ready", bus.in_ready, 1'b1);
    check("reset_done", frame_done, 1'b0);
    reset = 1'b1;
    idle_watch(2);

    run_frame(1'b0, 14'd42, 32'h00003004, 5'd5, 32'h0, 32'h0000abcd, 1'b1, -1,
              "^42@00003004: $5 <= 0000abcd#", w);
    run_frame(1'b1, 14'd0, 32'h00003000, 5'd0, 32'h00002ffc, 32'hffffffff, 1'b1, -1,
              "^0@00003000: *00002ffc <= ffffffff#", w);
    check("post_frame_gap", w, 1);
    run_frame(1'b0, 14'd9999, 32'h00003008, 5'd31, 32'h0, 32'h12345678, 1'b1, -1,
              "^9999@00003008: $31 <= 12345678#", w);
    run_frame(1'b1, 14'd12000, 32'hdeadbeef, 5'd0, 32'hcafef00d, 32'h0, 1'b1, -1,
              "^9999@deadbeef: *cafef00d <= 00000000#", w);
    run_frame(1'b0, 14'd10, 32'h0000300c, 5'd0, 32'h0, 32'h89abcdef, 1'b1, -1,
              "^10@0000300c: $0 <= 89abcdef#", w);
    run_frame(1'b0, 14'd100, 32'h00003010, 5'd10, 32'h0, 32'h00000001, 1'b1, -1,
              "^100@00003010: $10 <= 00000001#", w);
    idle_watch(3);

    // back-to-back with in_valid held: second accepted in the single idle cycle
    run_frame(1'b0, 14'd7, 32'h00003014, 5'd3, 32'h0, 32'h00000055, 1'b0, -1, "", w);
    run_frame(1'b1, 14'd1234, 32'h00003018, 5'd0, 32'h00000004, 32'h00000066, 1'b1, -1,
              "^1234@00003018: *00000004 <= 00000066#", w);
    check("b2b_accept_gap", w, 1);

    // reset while the third PC digit is on char (position 1 + 2 + 1 + 3)
    run_frame(1'b0, 14'd42, 32'h00003004, 5'd5, 32'h0, 32'h0000abcd, 1'b1, 7, "", w);
    idle_watch(40);
    run_frame(1'b0, 14'd42, 32'h00003004, 5'd5, 32'h0, 32'h0000abcd, 1'b1, -1,
              "^42@00003004: $5 <= 0000abcd#", w);

    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0:       t = 14'($urandom_range(0, 9));
        1:       t = 14'($urandom_range(10, 999));
        2:       t = 14'($urandom_range(1000, 9999));
        default: t = 14'($urandom_range(10000, 16383));
      endcase
      k = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(k, t, $urandom, 5'($urandom), $urandom, $urandom, 1'b1, -1, "", w);
    end
    idle_watch(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
